// File: rtl/hd_pkg.sv
// -----------------------------------------------------------------------------
// hd_pkg
// Shared constants and types for the hyperdimensional chunk accumulator.
//   HD_INPUT_WIDTH / HD_DIM_WIDTH / HD_FTSIZE / HD_CNT_WIDTH : parameter defaults
//   HD_TREE_LANES : fixed lane count of the adder tree (narrower chunks pad)
//   hd_state_e    : accumulator FSM states
// -----------------------------------------------------------------------------
package hd_pkg;

   localparam int unsigned HD_INPUT_WIDTH = 8;
   localparam int unsigned HD_DIM_WIDTH   = 16;
   localparam int unsigned HD_FTSIZE      = 32;
   localparam int unsigned HD_CNT_WIDTH   = 8;
   localparam int unsigned HD_TREE_LANES  = 32;

   // IDLE   : no partial sum held
   // ACCUM  : partial sum held in the tree output register
   // RESULT : final sum held, presented on the output port
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } hd_state_e;

endpackage

// File: rtl/pipelined_adder_tree_32.sv
// -----------------------------------------------------------------------------
// pipelined_adder_tree_32
// Sums 32 signed elements plus a carried-in value into one registered result.
// The output register is the only pipeline stage, so sum_o reflects the inputs
// of the previous clock.
// Ports:
//   clk       : clock, all state on posedge
//   reset     : synchronous active-high, clears the sum register
//   elem_i    : 32 signed two's-complement elements
//   last_in_i : value added to the element total (carried partial sum)
//   sum_o     : registered total, wraps modulo 2^DIM_WIDTH
// -----------------------------------------------------------------------------
module pipelined_adder_tree_32
   import hd_pkg::*;
#(
   parameter int unsigned INPUT_WIDTH = HD_INPUT_WIDTH,
   parameter int unsigned DIM_WIDTH   = HD_DIM_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [HD_TREE_LANES-1:0][INPUT_WIDTH-1:0] elem_i,
   input  logic [DIM_WIDTH-1:0]                    last_in_i,
   output logic [DIM_WIDTH-1:0]                    sum_o
);

   localparam int unsigned NODES = 2 * HD_TREE_LANES - 1;

   // Heap-ordered tree: leaves at [LANES-1 .. 2*LANES-2], root at [0].
   logic [DIM_WIDTH-1:0] node [NODES];
   logic [DIM_WIDTH-1:0] sum_d;
   logic [DIM_WIDTH-1:0] sum_q;

   always_comb begin
      for (int unsigned i = 0; i < HD_TREE_LANES; i++) begin
         node[HD_TREE_LANES - 1 + i] = DIM_WIDTH'($signed(elem_i[i]));
      end
      // Walk from the deepest internal node up so children are always ready.
      for (int unsigned j = HD_TREE_LANES - 1; j > 0; j--) begin
         node[j - 1] = node[2 * j - 1] + node[2 * j];
      end
      sum_d = node[0] + last_in_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/hd_chunk_accumulator.sv
// -----------------------------------------------------------------------------
// hd_chunk_accumulator
// Accumulates a vector delivered as a stream of FTSIZE-element signed chunks
// into one DIM_WIDTH signed sum, reported one cycle after the last chunk.
// The adder tree's output register doubles as the accumulator.
// Ports:
//   clk, reset           : single clock, synchronous active-high reset
//   in_valid / in_ready  : chunk handshake
//   in_data              : FTSIZE signed INPUT_WIDTH elements
//   in_last              : marks the final chunk of a vector
//   out_valid / out_ready: result handshake
//   out_data             : vector sum (or sign bit, see below)
//   out_chunks           : chunks in the reported vector, saturating
// Build option:
//   HD_BINARIZE_EN : out_data[0] = 1 when sum >= 0, upper bits zero
// FTSIZE must be 8, 16 or 32; unused tree lanes are fed zero.
// -----------------------------------------------------------------------------
module hd_chunk_accumulator
   import hd_pkg::*;
#(
   parameter int unsigned INPUT_WIDTH = HD_INPUT_WIDTH,
   parameter int unsigned DIM_WIDTH   = HD_DIM_WIDTH,
   parameter int unsigned FTSIZE      = HD_FTSIZE,
   parameter int unsigned CNT_WIDTH   = HD_CNT_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [FTSIZE-1:0][INPUT_WIDTH-1:0] in_data,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DIM_WIDTH-1:0]               out_data,
   output logic [CNT_WIDTH-1:0]               out_chunks
);

   hd_state_e state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic                                     beat;
   logic [HD_TREE_LANES-1:0][INPUT_WIDTH-1:0] tree_elem;
   logic [DIM_WIDTH-1:0]                     tree_last;
   logic [DIM_WIDTH-1:0]                     tree_sum;

   // Handshake and tree feed. Without a beat the tree adds zeros to its own
   // output, which holds the sum through bubbles and output backpressure.
   always_comb begin
      in_ready  = (state_q != RESULT) || out_ready;
      beat      = in_valid && in_ready;
      tree_elem = '0;
      if (beat) begin
         for (int unsigned i = 0; i < FTSIZE; i++) begin
            tree_elem[i] = in_data[i];
         end
      end
      // A beat outside ACCUM is the first chunk of a new vector.
      tree_last = (beat && (state_q != ACCUM)) ? '0 : tree_sum;
   end

   pipelined_adder_tree_32 #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .DIM_WIDTH   (DIM_WIDTH)
   ) u_tree (
      .clk       (clk),
      .reset     (reset),
      .elem_i    (tree_elem),
      .last_in_i (tree_last),
      .sum_o     (tree_sum)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (beat) begin
               state_d = in_last ? RESULT : ACCUM;
            end
         end
         RESULT: begin
            if (out_ready) begin
               if (beat) begin
                  state_d = in_last ? RESULT : ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (beat) begin
         if (state_q != ACCUM) begin
            cnt_d = CNT_WIDTH'(1);
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are masked by reset so they read zero for the whole reset pulse,
   // including its first cycle before the registers have cleared.
   always_comb begin
      out_valid  = (state_q == RESULT) && !reset;
      out_chunks = out_valid ? cnt_q : '0;
      out_data   = '0;
      if (out_valid) begin
`ifdef HD_BINARIZE_EN
         out_data[0] = ~tree_sum[DIM_WIDTH-1];
`else
         out_data = tree_sum;
`endif
      end
   end

endmodule

// File: tb/tb_hd_chunk_accumulator.sv
module tb_hd_chunk_accumulator;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [31:0][7:0]  in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_data;
   logic [7:0]        out_chunks;

   int checks = 0;
   int errors = 0;

   // Reference model state: an integer running total and a chunk count.
   bit exp_valid = 0;
   bit in_prog   = 0;
   int acc       = 0;
   int nchunks   = 0;
   int res_acc   = 0;
   int res_n     = 0;

   hd_chunk_accumulator #(
      .INPUT_WIDTH (8),
      .DIM_WIDTH   (16),
      .FTSIZE      (32),
      .CNT_WIDTH   (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_chunks (out_chunks)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [15:0] model_out(int total);
      logic [15:0] w;
      w = total[15:0];
`ifdef HD_BINARIZE_EN
      return {15'b0, ~w[15]};
`else
      return w;
`endif
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic fill(logic [7:0] v);
      for (int i = 0; i < 32; i++) in_data[i] = v;
   endtask

   // One clock: check in_ready, advance the model, clock, check outputs.
   task automatic cycle();
      bit rdy, beat;
      int s;
      #2;
      rdy = !exp_valid || out_ready;
      if (reset) begin
         exp_valid = 0;
         in_prog   = 0;
      end else begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
         beat = in_valid && rdy;
         if (exp_valid && out_ready) exp_valid = 0;
         if (beat) begin
            if (!in_prog) begin
               acc     = 0;
               nchunks = 0;
            end
            s = 0;
            for (int i = 0; i < 32; i++) s += int'($signed(in_data[i]));
            acc += s;
            nchunks++;
            if (in_last) begin
               exp_valid = 1;
               in_prog   = 0;
               res_acc   = acc;
               res_n     = (nchunks > 255) ? 255 : nchunks;
            end else begin
               in_prog = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
         chk("out_data", {16'b0, out_data}, {16'b0, model_out(res_acc)});
         chk("out_chunks", {24'b0, out_chunks}, res_n);
      end else if (reset) begin
         chk("rst_out_data", {16'b0, out_data}, 0);
         chk("rst_out_chunks", {24'b0, out_chunks}, 0);
      end
   endtask

   task automatic send(logic [7:0] v, bit last);
      in_valid = 1;
      fill(v);
      in_last = last;
      cycle();
      in_valid = 0;
      in_last  = 0;
   endtask

   initial begin
      reset = 1; in_valid = 0; in_last = 0; out_ready = 1; fill(8'h00);
      cycle();
      cycle();
      reset = 0;
      cycle();
      chk("ready_after_reset", {31'b0, in_ready}, 1);

      // Single chunk of -1.
      send(8'hFF, 1);
`ifdef HD_BINARIZE_EN
      chk("neg_chunk", {16'b0, out_data}, 32'h0000);
`else
      chk("neg_chunk", {16'b0, out_data}, 32'hFFE0);
`endif
      chk("neg_chunk_n", {24'b0, out_chunks}, 1);
      cycle();

      // Three back-to-back +1 chunks.
      send(8'h01, 0);
      send(8'h01, 0);
      send(8'h01, 1);
`ifndef HD_BINARIZE_EN
      chk("b2b_sum", {16'b0, out_data}, 32'h0060);
`endif
      chk("b2b_n", {24'b0, out_chunks}, 3);
      cycle();

      // Bubbles between chunks.
      send(8'h01, 0);
      cycle();
      cycle();
      send(8'h02, 1);
`ifndef HD_BINARIZE_EN
      chk("bubble_sum", {16'b0, out_data}, 32'h0060);
`endif
      chk("bubble_n", {24'b0, out_chunks}, 2);
      cycle();

      // Output backpressure while a new chunk waits, then same-cycle swap.
      out_ready = 0;
      send(8'h01, 1);
      in_valid = 1; fill(8'h03); in_last = 1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_in_ready", {31'b0, in_ready}, 0);
`ifndef HD_BINARIZE_EN
         chk("bp_hold", {16'b0, out_data}, 32'h0020);
`endif
      end
      out_ready = 1;
      cycle();
      in_valid = 0; in_last = 0;
`ifndef HD_BINARIZE_EN
      chk("swap_sum", {16'b0, out_data}, 32'h0060);
`endif
      chk("swap_n", {24'b0, out_chunks}, 1);
      cycle();

      // Nine 0x7F chunks wrap past 2^15.
      for (int k = 0; k < 8; k++) send(8'h7F, 0);
      send(8'h7F, 1);
`ifndef HD_BINARIZE_EN
      chk("wrap_sum", {16'b0, out_data}, 32'h8EE0);
`endif
      chk("wrap_n", {24'b0, out_chunks}, 9);
      cycle();

      // Reset mid-vector discards the partial sum.
      send(8'h01, 0);
      send(8'h01, 0);
      reset = 1;
      cycle();
      reset = 0;
      send(8'h01, 1);
`ifndef HD_BINARIZE_EN
      chk("rst_mid_sum", {16'b0, out_data}, 32'h0020);
`endif
      chk("rst_mid_n", {24'b0, out_chunks}, 1);
      cycle();

      // Chunk counter saturation.
      for (int k = 0; k < 259; k++) send(8'(k % 5), 0);
      send(8'h01, 1);
      chk("sat_n", {24'b0, out_chunks}, 255);
      cycle();

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         reset     = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < 32; i++) in_data[i] = 8'($urandom);
         cycle();
      end
      reset = 0; in_valid = 0; out_ready = 1;
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hd_chunk_accumulator.md
HD_CHUNK_ACCUMULATOR -- requirements
Module: hd_chunk_accumulator

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8, signed element width per feature.
REQ-002 SHALL have parameter DIM_WIDTH, default 16, signed accumulator/result width.
REQ-003 SHALL have parameter FTSIZE, default 32, elements per chunk. Only 8/16/32 are supported.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, chunk-count width.
REQ-005 SHALL have port clk, input, 1, sole clock: one clock, all state on posedge clk.
REQ-006 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, chunk beat offered.
REQ-008 SHALL have port in_ready, output, 1, chunk beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_data, input, [FTSIZE-1:0][INPUT_WIDTH-1:0], signed two's-complement chunk.
REQ-010 SHALL have port in_last, input, 1, final chunk of the current vector.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-013 SHALL have port out_data, output, DIM_WIDTH, vector result.
REQ-014 SHALL have port out_chunks, output, CNT_WIDTH, number of chunks in the reported vector, saturating at all-ones.

Function
REQ-015 SHALL use FSM states IDLE (no partial sum), ACCUM (partial sum held), RESULT (final sum held, out_valid=1).
REQ-016 SHALL make these transitions:
- IDLE/ACCUM + beat with !in_last -> ACCUM.
- IDLE/ACCUM + beat with in_last -> RESULT.
- RESULT + out handshake without beat -> IDLE.
- RESULT + out handshake with beat -> ACCUM or RESULT, per in_last.
REQ-017 SHALL drive in_ready = (state != RESULT) || out_ready, so consuming a result and accepting a new first chunk can happen in the same cycle.
REQ-018 SHALL feed each accepted chunk to the tree with last_in = 0 if the state is IDLE or RESULT (first chunk), else last_in = the tree's registered sum.
REQ-019 SHALL, on cycles with no beat, feed the tree all-zero elements with last_in = the registered sum, so the sum holds unchanged through bubbles and backpressure.
REQ-020 SHALL have a latency of 1 cycle: in_last accepted at cycle t gives out_valid=1 at t+1. Back-to-back beats at full rate (one per cycle) are sustained.
REQ-021 SHALL sign-extend elements to DIM_WIDTH; the sum wraps modulo 2^DIM_WIDTH with no saturation and no flag.
REQ-022 SHALL keep out_data and out_chunks stable while out_valid && !out_ready.
REQ-023 SHALL count the chunk counter from 1 on the first chunk and increment it per beat, saturating at 2^CNT_WIDTH-1; out_chunks SHALL equal the counter in RESULT.
REQ-024 SHALL ignore in_data and in_last when in_ready=0.

Reset
REQ-025 SHALL, while reset=1, force state=IDLE, tree sum=0, chunk counter=0, out_valid=0, out_data=0, out_chunks=0. in_ready SHALL be 1 after release.
REQ-026 SHALL discard a partial vector when reset is asserted mid-vector; the next beat after release starts a fresh vector.

Configuration
REQ-027 SHALL, with macro HD_BINARIZE_EN defined, drive out_data[0] = ~sum[DIM_WIDTH-1] (1 when sum >= 0) and out_data[DIM_WIDTH-1:1] = 0.
REQ-028 SHALL, without HD_BINARIZE_EN, drive out_data = full signed sum. Handshake and timing SHALL be identical in both builds.

Structure
REQ-029 SHALL place INPUT_WIDTH/DIM_WIDTH/FTSIZE default constants and the FSM state enum typedef in shared package hd_pkg.
REQ-030 SHALL instantiate the existing pipelined_adder_tree_32 as its single sub-module. The tree's output register is the accumulator; no second sum register is allowed.

Verification
REQ-031 SHALL cover: one chunk of all -1 with in_last -> next cycle out_valid=1, out_data=0xFFE0, out_chunks=1 (binarized build: out_data=0x0000).
REQ-032 SHALL cover: three back-to-back all-+1 chunks, last flagged -> out_data=0x0060 one cycle after the third beat, out_chunks=3.
REQ-033 SHALL cover: chunk of +1s, 2 idle cycles, chunk of +2s with in_last -> out_data=0x0060, out_chunks=2.
REQ-034 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_data stable; then out_ready=1 -> result consumed and new chunk accepted in that same cycle.
REQ-035 SHALL cover: nine all-0x7F chunks -> out_data=0x8EE0 (wrapped), out_chunks=9.
REQ-036 SHALL cover: reset after 2 of 3 chunks, then a single +1 chunk with in_last -> out_data=0x0020, out_chunks=1.
